// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and encodings for the oversampling UART receiver
//
// Purpose: receiver state encoding, parity-mode codes and error-flag bit
// positions shared between the receiver and anything that decodes its output.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_STOP2,
    ST_BRK_WAIT
  } rx_state_e;

  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // m_err_o = {break, frame, parity}
  localparam int ERR_W      = 3;
  localparam int ERR_PARITY = 0;
  localparam int ERR_FRAME  = 1;
  localparam int ERR_BREAK  = 2;

endpackage

// File: rtl/uart_rx_ovs.sv
// rtl/uart_rx_ovs.sv - oversampling UART receiver with frame checks and receive FIFO
//
// Purpose: receives asynchronous serial frames on rxd_i with OVS-times
// oversampling and 3-sample majority vote, checks parity/stop/break, and
// queues each word with its error flags in a FIFO drained by a valid/ready
// stream.
//
// Ports:
//   clk_i, rst_i        system clock, synchronous active-high reset
//   en_i                receiver enable; low aborts any frame in progress
//   baud_div_i          clocks per oversample tick minus 1
//   data_bits_i         data bits per frame (5..MAX_DATA_W, others clamp)
//   parity_i            00/11 none, 01 even, 10 odd
//   stop2_i             two stop bits
//   rxd_i               asynchronous serial line, idle high
//   m_data_o            head-of-FIFO data, LSB first received, MSBs zero
//   m_err_o             head-of-FIFO {break, frame, parity}
//   m_valid_o           FIFO not empty
//   m_ready_i           consumer accepts head word
//   overrun_o           one-cycle pulse when a finished word is dropped
//   fifo_level_o        FIFO occupancy 0..FIFO_DEPTH
//   busy_o              receiver not idle
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int MAX_DATA_W = 8,
  parameter int OVS        = 16,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic [DIV_W-1:0]              baud_div_i,
  input  logic [3:0]                    data_bits_i,
  input  logic [1:0]                    parity_i,
  input  logic                          stop2_i,
  input  logic                          rxd_i,
  output logic [MAX_DATA_W-1:0]         m_data_o,
  output logic [2:0]                    m_err_o,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic                          overrun_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          busy_o
);

  localparam int SW = $clog2(OVS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = MAX_DATA_W + ERR_W;

  localparam logic [SW-1:0] IDX_A    = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] IDX_B    = SW'(OVS / 2);
  localparam logic [SW-1:0] IDX_C    = SW'(OVS / 2 + 1);
  localparam logic [SW-1:0] IDX_LAST = SW'(OVS - 1);
  localparam logic [3:0]    MAXW4    = 4'(MAX_DATA_W);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  // ---------------------------------------------------------------------
  // Receiver state
  // ---------------------------------------------------------------------
  logic [1:0]            sync_q, sync_d;
  logic                  prev_q, prev_d;
  rx_state_e             state_q, state_d;
  logic [DIV_W-1:0]      tick_cnt_q, tick_cnt_d;
  logic [SW-1:0]         samp_q, samp_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [3:0]            bits_q, bits_d;
  logic [1:0]            par_q, par_d;
  logic                  stop2_q, stop2_d;
  logic                  s1_q, s1_d;
  logic                  s2_q, s2_d;
  logic [MAX_DATA_W-1:0] shreg_q, shreg_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic                  par_acc_q, par_acc_d;
  logic                  zero_q, zero_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  wr_req_q, wr_req_d;
  logic [MAX_DATA_W-1:0] wr_data_q, wr_data_d;
  logic [ERR_W-1:0]      wr_err_q, wr_err_d;

  // ---------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------
  logic [EW-1:0]         mem_q [FIFO_DEPTH];
  logic [EW-1:0]         mem_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         count_q, count_d;

  logic                  rxd_s;
  logic                  fall;
  logic                  tick;
  logic                  resolve;
  logic                  vote;
  logic                  par_on;
  logic [3:0]            bits_clamp;
  logic [MAX_DATA_W-1:0] data_aligned;
  logic                  pop;
  logic                  full;
  logic                  do_wr;
  logic [EW-1:0]         head;

  assign rxd_s   = sync_q[1];
  assign fall    = prev_q & ~rxd_s;
  assign tick    = (tick_cnt_q == div_q);
  // The third sample is taken live; the first two were captured earlier.
  assign resolve = tick && (samp_q == IDX_C);
  assign vote    = (s1_q & s2_q) | (s1_q & rxd_s) | (s2_q & rxd_s);
  assign par_on  = (par_q == PAR_EVEN) || (par_q == PAR_ODD);

  assign bits_clamp = ((data_bits_i < 4'd5) || (data_bits_i > MAXW4)) ? MAXW4 : data_bits_i;

  // Bits shift in from the top, so a short word sits in the upper bits and
  // must be moved down to make LSB = first received bit.
  assign data_aligned = shreg_q >> (MAXW4 - bits_q);

  // ---------------------------------------------------------------------
  // Receiver next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    sync_d     = {sync_q[0], rxd_i};
    prev_d     = rxd_s;
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    samp_d     = samp_q;
    div_d      = div_q;
    bits_d     = bits_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    par_acc_d  = par_acc_q;
    zero_d     = zero_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    wr_req_d   = 1'b0;
    wr_data_d  = wr_data_q;
    wr_err_d   = wr_err_q;

    // Tick and sample counters free-run across bit boundaries while a frame
    // is active; a state change at the resolve index leaves the counter to
    // finish the current bit before the next bit's indices come round.
    if (state_q != ST_IDLE) begin
      if (tick) begin
        tick_cnt_d = '0;
        samp_d     = (samp_q == IDX_LAST) ? '0 : samp_q + SW'(1);
        if (samp_q == IDX_A) s1_d = rxd_s;
        if (samp_q == IDX_B) s2_d = rxd_s;
      end else begin
        tick_cnt_d = tick_cnt_q + DIV_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (en_i && fall) begin
          state_d    = ST_START;
          tick_cnt_d = '0;
          samp_d     = '0;
          div_d      = baud_div_i;
          bits_d     = bits_clamp;
          par_d      = parity_i;
          stop2_d    = stop2_i;
          shreg_d    = '0;
          bit_cnt_d  = '0;
          par_acc_d  = 1'b0;
          zero_d     = 1'b1;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
        end
      end

      ST_START: begin
        if (resolve) begin
          state_d = vote ? ST_IDLE : ST_DATA;
        end
      end

      ST_DATA: begin
        if (resolve) begin
          shreg_d   = {vote, shreg_q[MAX_DATA_W-1:1]};
          par_acc_d = par_acc_q ^ vote;
          if (vote) zero_d = 1'b0;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == bits_q - 4'd1) begin
            state_d = par_on ? ST_PARITY : ST_STOP;
          end
        end
      end

      ST_PARITY: begin
        if (resolve) begin
          perr_d  = vote ^ par_acc_q ^ (par_q == PAR_ODD);
          if (vote) zero_d = 1'b0;
          state_d = ST_STOP;
        end
      end

      ST_STOP: begin
        if (resolve) begin
          if (!vote && zero_q) begin
            wr_req_d  = 1'b1;
            wr_data_d = '0;
            wr_err_d  = {1'b1, 1'b1, perr_q};
            state_d   = ST_BRK_WAIT;
          end else if (stop2_q) begin
            ferr_d  = ~vote;
            state_d = ST_STOP2;
          end else begin
            wr_req_d  = 1'b1;
            wr_data_d = data_aligned;
            wr_err_d  = {1'b0, ~vote, perr_q};
            state_d   = ST_IDLE;
          end
        end
      end

      ST_STOP2: begin
        if (resolve) begin
          wr_req_d  = 1'b1;
          wr_data_d = data_aligned;
          wr_err_d  = {1'b0, ferr_q | ~vote, perr_q};
          state_d   = ST_IDLE;
        end
      end

      ST_BRK_WAIT: begin
        if (rxd_s) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (!en_i) begin
      state_d  = ST_IDLE;
      wr_req_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // FIFO next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    pop   = (count_q != '0) && m_ready_i;
    full  = (count_q == FULL_LVL);
    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    do_wr = wr_req_q && (!full || pop);

    mem_d = mem_q;
    if (do_wr) mem_d[wr_ptr_q] = {wr_err_q, wr_data_q};

    wr_ptr_d = do_wr ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + LW'(do_wr) - LW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q     <= 2'b11;
      prev_q     <= 1'b1;
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      samp_q     <= '0;
      div_q      <= '0;
      bits_q     <= MAXW4;
      par_q      <= 2'b00;
      stop2_q    <= 1'b0;
      s1_q       <= 1'b1;
      s2_q       <= 1'b1;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      par_acc_q  <= 1'b0;
      zero_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      wr_req_q   <= 1'b0;
      wr_data_q  <= '0;
      wr_err_q   <= '0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      samp_q     <= samp_d;
      div_q      <= div_d;
      bits_q     <= bits_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      par_acc_q  <= par_acc_d;
      zero_q     <= zero_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      wr_req_q   <= wr_req_d;
      wr_data_q  <= wr_data_d;
      wr_err_q   <= wr_err_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign head         = mem_q[rd_ptr_q];
  assign m_valid_o    = (count_q != '0);
  assign m_data_o     = m_valid_o ? head[MAX_DATA_W-1:0] : '0;
  assign m_err_o      = m_valid_o ? head[EW-1:MAX_DATA_W] : '0;
  assign overrun_o    = wr_req_q && full && !pop;
  assign fifo_level_o = count_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb/tb_uart_rx_ovs.sv - scoreboard bench for the oversampling UART receiver
module tb_uart_rx_ovs;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] baud_div;
  logic [3:0]  data_bits;
  logic [1:0]  parity;
  logic        stop2;
  logic        rxd;
  logic [7:0]  m_data;
  logic [2:0]  m_err;
  logic        m_valid;
  logic        m_ready;
  logic        overrun;
  logic [3:0]  fifo_level;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int ovr_cnt  = 0;
  logic busy_seen = 1'b0;

  // expected entries: {err[2:0], data[7:0]}
  logic [10:0] exp_q[$];

  uart_rx_ovs #(
    .MAX_DATA_W (8),
    .OVS        (16),
    .DIV_W      (16),
    .FIFO_DEPTH (8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .baud_div_i   (baud_div),
    .data_bits_i  (data_bits),
    .parity_i     (parity),
    .stop2_i      (stop2),
    .rxd_i        (rxd),
    .m_data_o     (m_data),
    .m_err_o      (m_err),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready),
    .overrun_o    (overrun),
    .fifo_level_o (fifo_level),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output word is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (overrun) ovr_cnt++;
      if (busy) busy_seen = 1'b1;
      if (m_valid && m_ready) begin
        logic [10:0] e;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word actual=0x%0h required=none", {m_err, m_data});
        end else begin
          e = exp_q.pop_front();
          if ({m_err, m_data} !== e) begin
            failures++;
            $display("FAIL rx_word actual=0x%0h required=0x%0h", {m_err, m_data}, e);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input int nbits, input logic [1:0] par,
                            input logic two_stop, input logic flip_par, input int bclk);
    logic p;
    p = 1'b0;
    rxd = 1'b0;
    step(bclk);
    for (int i = 0; i < nbits; i++) begin
      rxd = data[i];
      p   = p ^ data[i];
      step(bclk);
    end
    if (par == 2'b01 || par == 2'b10) begin
      rxd = p ^ (par == 2'b10) ^ flip_par;
      step(bclk);
    end
    rxd = 1'b1;
    step((two_stop ? 2 : 1) * bclk - 1);
    chk("busy_low_in_stop", busy, 1'b0);
    step(1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; baud_div = 16'd0; data_bits = 4'd8; parity = 2'b00;
    stop2 = 1'b0; rxd = 1'b1; m_ready = 1'b1;

    // reset values
    step(3);
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_level", fifo_level, 4'd0);
    chk("rst_busy",  busy, 1'b0);
    chk("rst_data",  m_data, 8'h00);
    chk("rst_err",   m_err, 3'b000);
    chk("rst_ovr",   overrun, 1'b0);
    rst = 1'b0;
    step(5);

    // 8N1 0xA5
    exp_q.push_back({3'b000, 8'hA5});
    send_frame(8'hA5, 8, 2'b00, 1'b0, 1'b0, 16);
    step(4);
    chk("t1_drained", exp_q.size(), 0);

    // 7E2, divisor 2: bad parity then good
    baud_div = 16'd2; data_bits = 4'd7; parity = 2'b01; stop2 = 1'b1;
    exp_q.push_back({3'b001, 8'h35});
    exp_q.push_back({3'b000, 8'h35});
    send_frame(8'h35, 7, 2'b01, 1'b1, 1'b1, 48);
    send_frame(8'h35, 7, 2'b01, 1'b1, 1'b0, 48);
    step(4);
    chk("t2_drained", exp_q.size(), 0);

    // short low glitch: false start
    baud_div = 16'd0; data_bits = 4'd8; parity = 2'b00; stop2 = 1'b0;
    busy_seen = 1'b0;
    rxd = 1'b0;
    step(6);
    rxd = 1'b1;
    step(40);
    chk("glitch_busy_pulse", busy_seen, 1'b1);
    chk("glitch_idle", busy, 1'b0);
    chk("glitch_level", fifo_level, 4'd0);

    // break: line low for 3 frame times
    exp_q.push_back({3'b110, 8'h00});
    rxd = 1'b0;
    step(480);
    chk("brk_word_seen", exp_q.size(), 0);
    chk("brk_wait_busy", busy, 1'b1);
    rxd = 1'b1;
    step(20);
    chk("brk_idle", busy, 1'b0);
    exp_q.push_back({3'b000, 8'h3C});
    send_frame(8'h3C, 8, 2'b00, 1'b0, 1'b0, 16);
    step(4);
    chk("t4_drained", exp_q.size(), 0);

    // FIFO fill and overrun
    m_ready = 1'b0;
    chk("pre_ovr_cnt", ovr_cnt, 0);
    for (int i = 1; i <= 8; i++) exp_q.push_back({3'b000, 8'(i)});
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 8, 2'b00, 1'b0, 1'b0, 16);
    step(4);
    chk("full_level", fifo_level, 4'd8);
    chk("full_valid", m_valid, 1'b1);
    chk("full_head",  m_data, 8'h01);
    chk("ovr_pulses", ovr_cnt, 1);
    m_ready = 1'b1;
    step(12);
    chk("drain_level", fifo_level, 4'd0);
    chk("t5_drained", exp_q.size(), 0);

    // reset during DATA of 0x55
    rxd = 1'b0; step(16);
    rxd = 1'b1; step(16);
    rxd = 1'b0; step(16);
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    rxd = 1'b1;
    step(2);
    chk("mid_rst_busy",  busy, 1'b0);
    chk("mid_rst_valid", m_valid, 1'b0);
    chk("mid_rst_level", fifo_level, 4'd0);
    chk("mid_rst_data",  m_data, 8'h00);
    chk("mid_rst_err",   m_err, 3'b000);
    step(3);
    rst = 1'b0;
    step(40);
    chk("post_rst_idle", busy, 1'b0);
    exp_q.push_back({3'b000, 8'hC3});
    send_frame(8'hC3, 8, 2'b00, 1'b0, 1'b0, 16);
    step(6);
    chk("t6_drained", exp_q.size(), 0);
    chk("final_level", fifo_level, 4'd0);
    chk("final_ovr_cnt", ovr_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
